udc_config_sequencer: RTL

- Bus-master stage directly upstream of the 8-bit up/down counter.
- Accepts a complete configuration (preload, upper limit, lower limit, cycle count) on a one-cycle `go` request.
- Writes the configuration into the counter's PLR/ULR/LLR/CCR registers over the counter's ncs/nwr/nrd/A1A0/Din bus, optionally reads it back, issues the start pulse, then waits for end-cycle or error.
- Reports one status code per transaction, so higher-level control never drives the counter bus directly.

---
 rtl/udc_config_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/udc_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : udc_config_sequencer
// Brief    : Programs, optionally reads back, and starts the 8-bit up/down
//            counter, then reports one status code per transaction.
// Revision : 1.0 - initial release
// ============================================================================
module udc_config_sequencer #(
  parameter int VERIFY         = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] cfg_plr,
  input  logic [7:0] cfg_ulr,
  input  logic [7:0] cfg_llr,
  input  logic [7:0] cfg_ccr,
  output logic       busy,
  output logic       done,
  output logic [2:0] status,
  inout  wire  [7:0] din,
  output logic       ncs,
  output logic       nwr,
  output logic       nrd,
  output logic       a1,
  output logic       a0,
  output logic       start,
  input  logic       ec,
  input  logic       err
);

  localparam logic [2:0]  C_ST_OK     = 3'd0;
  localparam logic [2:0]  C_ST_BADCFG = 3'd1;
  localparam logic [2:0]  C_ST_CNTERR = 3'd2;
  localparam logic [2:0]  C_ST_RBMIS  = 3'd3;
  localparam logic [2:0]  C_ST_TMO    = 3'd4;
  localparam logic [15:0] C_TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CHECK   = 4'd1,
    S_WR_PLR  = 4'd2,
    S_WR_ULR  = 4'd3,
    S_WR_LLR  = 4'd4,
    S_WR_CCR  = 4'd5,
    S_RD_A    = 4'd6,
    S_RD_B    = 4'd7,
    S_GAP     = 4'd8,
    S_START   = 4'd9,
    S_WAIT_EC = 4'd10,
    S_FIN     = 4'd11
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_plr;
  logic [7:0]  r_ulr;
  logic [7:0]  r_llr;
  logic [7:0]  r_ccr;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_next;
  logic [15:0] r_tmo;
  logic [2:0]  r_status;
  logic [2:0]  w_status_next;
  logic        w_oe;
  logic [7:0]  w_dout;
  logic [7:0]  w_rd_expect;
  logic [1:0]  w_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_status <= C_ST_OK;
      r_tmo    <= 16'd0;
      r_idx    <= 2'd0;
      r_plr    <= 8'd0;
      r_ulr    <= 8'd0;
      r_llr    <= 8'd0;
      r_ccr    <= 8'd0;
    end else begin
      r_state  <= w_next;
      r_status <= w_status_next;
      r_idx    <= w_idx_next;
      r_tmo    <= (r_state == S_WAIT_EC) ? r_tmo + 16'd1 : 16'd0;
      if (r_state == S_IDLE && go) begin
        r_plr <= cfg_plr;
        r_ulr <= cfg_ulr;
        r_llr <= cfg_llr;
        r_ccr <= cfg_ccr;
      end
    end
  end

  // Readback reference follows the same PLR/ULR/LLR/CCR order as the address map.
  always_comb begin
    case (r_idx)
      2'd0:    w_rd_expect = r_plr;
      2'd1:    w_rd_expect = r_ulr;
      2'd2:    w_rd_expect = r_llr;
      default: w_rd_expect = r_ccr;
    endcase
  end

  always_comb begin
    w_next        = r_state;
    w_status_next = r_status;
    w_idx_next    = r_idx;
    w_oe          = 1'b0;
    w_dout        = 8'h00;
    w_addr        = 2'b00;
    ncs           = 1'b1;
    nrd           = 1'b1;
    start         = 1'b0;
    done          = 1'b0;
    busy          = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (go) begin
          w_next        = S_CHECK;
          w_status_next = C_ST_OK;
        end
      end
      S_CHECK: begin
        if (r_llr <= r_plr && r_plr <= r_ulr) begin
          w_next = S_WR_PLR;
        end else begin
          w_next        = S_FIN;
          w_status_next = C_ST_BADCFG;
        end
      end
      S_WR_PLR: begin
        ncs = 1'b0; w_oe = 1'b1; w_addr = 2'd0; w_dout = r_plr;
        w_next = S_WR_ULR;
      end
      S_WR_ULR: begin
        ncs = 1'b0; w_oe = 1'b1; w_addr = 2'd1; w_dout = r_ulr;
        w_next = S_WR_LLR;
      end
      S_WR_LLR: begin
        ncs = 1'b0; w_oe = 1'b1; w_addr = 2'd2; w_dout = r_llr;
        w_next = S_WR_CCR;
      end
      S_WR_CCR: begin
        ncs = 1'b0; w_oe = 1'b1; w_addr = 2'd3; w_dout = r_ccr;
        w_idx_next = 2'd0;
        w_next     = (VERIFY != 0) ? S_RD_A : S_GAP;
      end
      S_RD_A: begin
        ncs = 1'b0; nrd = 1'b0; w_addr = r_idx;
        w_next = S_RD_B;
      end
      S_RD_B: begin
        ncs = 1'b0; nrd = 1'b0; w_addr = r_idx;
        if (din != w_rd_expect) begin
          w_next        = S_FIN;
          w_status_next = C_ST_RBMIS;
        end else if (r_idx == 2'd3) begin
          w_next = S_GAP;
        end else begin
          w_idx_next = r_idx + 2'd1;
          w_next     = S_RD_A;
        end
      end
      S_GAP: begin
        ncs    = 1'b0;
        w_next = S_START;
      end
      S_START: begin
        ncs   = 1'b0;
        start = 1'b1;
        w_next = (r_ccr == 8'd0) ? S_FIN : S_WAIT_EC;
      end
      S_WAIT_EC: begin
        ncs = 1'b0;
        if (err) begin
          w_next        = S_FIN;
          w_status_next = C_ST_CNTERR;
        end else if (ec) begin
          w_next        = S_FIN;
          w_status_next = C_ST_OK;
        end else if (r_tmo == C_TMO_LAST) begin
          w_next        = S_FIN;
          w_status_next = C_ST_TMO;
        end
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    nwr = ~w_oe;
  end

  assign a1     = w_addr[1];
  assign a0     = w_addr[0];
  assign status = r_status;
  assign din    = w_oe ? w_dout : 8'bz;

endmodule
`default_nettype wire
